// File: rtl/player_motion_if.sv
// Cursor motion bundle between the VGA timing/button side and the renderer.
// The master drives vsync and the buttons; the slave (player_motion) returns the cursor coordinates.
interface player_motion_if;
  logic        vsync;
  logic [3:0]  p1_btn;
  logic [3:0]  p2_btn;
  logic [15:0] posx;
  logic [15:0] posy;
  logic [15:0] posx2;
  logic [15:0] posy2;
  logic        frame_tick;

  modport master (
    output vsync, p1_btn, p2_btn,
    input  posx, posy, posx2, posy2, frame_tick
  );

  modport slave (
    input  vsync, p1_btn, p2_btn,
    output posx, posy, posx2, posy2, frame_tick
  );
endinterface

// File: rtl/player_motion.sv
// Two-player cursor motion: button sync, vsync frame detect, clamped once-per-frame moves with overlap blocking.
// Define PLAYER_MOTION_ACCEL_EN to enable the per-player hold counters that double the step.
module player_motion #(
  parameter int MAX_X  = 640,
  parameter int MAX_Y  = 480,
  parameter int CURSOR = 20,
  parameter int STEP   = 2,
  parameter int P1_X0  = 100,
  parameter int P1_Y0  = 100,
  parameter int P2_X0  = 500,
  parameter int P2_Y0  = 100
`ifdef PLAYER_MOTION_ACCEL_EN
  , parameter int ACCEL_FRAMES = 16
`endif
) (
  input  logic dclk,
  input  logic clr,
  player_motion_if.slave bus
);

  localparam logic signed [16:0] X_LIM = 17'(MAX_X - CURSOR);
  localparam logic signed [16:0] Y_LIM = 17'(MAX_Y - CURSOR);
  localparam logic signed [16:0] CUR   = 17'(CURSOR);

  logic [3:0]  r_p1_s1, r_p1_s2, r_p2_s1, r_p2_s2;
  logic        r_vs_d;
  logic        r_frame_tick;
  logic [15:0] r_posx, r_posy, r_posx2, r_posy2;

  logic [15:0] w_step1, w_step2;
  logic [15:0] w_cx1, w_cy1, w_cx2, w_cy2;
  logic signed [16:0] w_dx, w_dy, w_adx, w_ady;
  logic        w_overlap;

  // Signed 17-bit step then saturate, so a step past either edge can never wrap.
  function automatic logic [15:0] f_axis(
    input logic [15:0]        pos,
    input logic               dec,
    input logic               inc,
    input logic [15:0]        step,
    input logic signed [16:0] lim
  );
    logic signed [16:0] v;
    v = signed'({1'b0, pos});
    if (dec && !inc)
      v = v - signed'({1'b0, step});
    else if (inc && !dec)
      v = v + signed'({1'b0, step});
    if (v < 17'sd0)
      v = 17'sd0;
    else if (v > lim)
      v = lim;
    return v[15:0];
  endfunction

`ifdef PLAYER_MOTION_ACCEL_EN
  logic [4:0] r_hold1, r_hold2;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else if (r_frame_tick) begin
      r_hold1 <= (|r_p1_s2) ? ((r_hold1 == 5'd31) ? r_hold1 : r_hold1 + 5'd1) : 5'd0;
      r_hold2 <= (|r_p2_s2) ? ((r_hold2 == 5'd31) ? r_hold2 : r_hold2 + 5'd1) : 5'd0;
    end
  end

  // The count before this tick's increment decides the step, so frame ACCEL_FRAMES+1 is the first fast one.
  assign w_step1 = (r_hold1 >= 5'(ACCEL_FRAMES)) ? 16'(2 * STEP) : 16'(STEP);
  assign w_step2 = (r_hold2 >= 5'(ACCEL_FRAMES)) ? 16'(2 * STEP) : 16'(STEP);
`else
  assign w_step1 = 16'(STEP);
  assign w_step2 = 16'(STEP);
`endif

  // Button order {up,down,left,right}: up/left decrement, down/right increment.
  assign w_cx1 = f_axis(r_posx,  r_p1_s2[1], r_p1_s2[0], w_step1, X_LIM);
  assign w_cy1 = f_axis(r_posy,  r_p1_s2[3], r_p1_s2[2], w_step1, Y_LIM);
  assign w_cx2 = f_axis(r_posx2, r_p2_s2[1], r_p2_s2[0], w_step2, X_LIM);
  assign w_cy2 = f_axis(r_posy2, r_p2_s2[3], r_p2_s2[2], w_step2, Y_LIM);

  assign w_dx  = signed'({1'b0, w_cx1}) - signed'({1'b0, w_cx2});
  assign w_dy  = signed'({1'b0, w_cy1}) - signed'({1'b0, w_cy2});
  assign w_adx = (w_dx < 17'sd0) ? -w_dx : w_dx;
  assign w_ady = (w_dy < 17'sd0) ? -w_dy : w_dy;
  assign w_overlap = (w_adx < CUR) && (w_ady < CUR);

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_p1_s1      <= '0;
      r_p1_s2      <= '0;
      r_p2_s1      <= '0;
      r_p2_s2      <= '0;
      r_vs_d       <= 1'b1;
      r_frame_tick <= 1'b0;
      r_posx       <= 16'(P1_X0);
      r_posy       <= 16'(P1_Y0);
      r_posx2      <= 16'(P2_X0);
      r_posy2      <= 16'(P2_Y0);
    end else begin
      r_p1_s1      <= bus.p1_btn;
      r_p1_s2      <= r_p1_s1;
      r_p2_s1      <= bus.p2_btn;
      r_p2_s2      <= r_p2_s1;
      r_vs_d       <= bus.vsync;
      r_frame_tick <= r_vs_d & ~bus.vsync;
      // An overlapping pair of candidates freezes both players for this frame.
      if (r_frame_tick && !w_overlap) begin
        r_posx  <= w_cx1;
        r_posy  <= w_cy1;
        r_posx2 <= w_cx2;
        r_posy2 <= w_cy2;
      end
    end
  end

  assign bus.posx       = r_posx;
  assign bus.posy       = r_posy;
  assign bus.posx2      = r_posx2;
  assign bus.posy2      = r_posy2;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: reset, moves, clamps, opposite buttons, diagonal and overlap blocking.
// With PLAYER_MOTION_ACCEL_EN defined the acceleration sequence expects the fast step.
`timescale 1ns/1ps
module tb_player_motion;
  logic dclk = 1'b0;
  logic clr;
  int   n_vec = 0;
  int   n_err = 0;
  int   e_x1, e_y1, e_x2, e_y2;

  player_motion_if bus();

  player_motion dut (
    .dclk (dclk),
    .clr  (clr),
    .bus  (bus)
  );

  always #20 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge dclk);
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, "_x1"}, 32'(bus.posx),  32'(e_x1));
    chk({tag, "_y1"}, 32'(bus.posy),  32'(e_y1));
    chk({tag, "_x2"}, 32'(bus.posx2), 32'(e_x2));
    chk({tag, "_y2"}, 32'(bus.posy2), 32'(e_y2));
  endtask

  // One vsync low pulse; at the tick cycle the outputs must still hold the previous frame's values.
  task automatic frame();
    bit got;
    got = 1'b0;
    @(negedge dclk);
    bus.vsync = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge dclk);
      if (bus.frame_tick) got = 1'b1;
    end
    if (!got) chk("tick_timeout", 32'd0, 32'd1);
    else begin
      chk("pre_x1", 32'(bus.posx),  32'(e_x1));
      chk("pre_x2", 32'(bus.posx2), 32'(e_x2));
    end
    @(negedge dclk);
    chk("tick_width", 32'(bus.frame_tick), 32'd0);
    cycles(2);
    bus.vsync = 1'b1;
    cycles(4);
  endtask

  // Reset asserted mid-frame; outputs must return to reset values without a clock edge.
  task automatic do_reset();
    cycles(3);
    @(negedge dclk);
    bus.vsync  = 1'b0;
    #5;
    clr        = 1'b1;
    #1;
    e_x1 = 100; e_y1 = 100; e_x2 = 500; e_y2 = 100;
    chk_pos("reset");
    chk("reset_tick", 32'(bus.frame_tick), 32'd0);
    bus.p1_btn = 4'b0000;
    bus.p2_btn = 4'b0000;
    bus.vsync  = 1'b1;
    cycles(2);
    clr = 1'b0;
    cycles(3);
  endtask

  initial begin
    clr        = 1'b1;
    bus.vsync  = 1'b1;
    bus.p1_btn = 4'b0000;
    bus.p2_btn = 4'b0000;
    e_x1 = 100; e_y1 = 100; e_x2 = 500; e_y2 = 100;
    cycles(2);
    chk_pos("init");
    clr = 1'b0;
    cycles(2);

    // p1 right for 10 frames
    do_reset();
    bus.p1_btn = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      frame();
      e_x1 = 100 + 2 * k;
      chk_pos("move");
    end
    bus.p1_btn = 4'b0010;
    bus.p2_btn = 4'b1111;
    cycles(10);
    chk_pos("between_ticks");

    // Opposite vertical buttons cancel, right still moves
    do_reset();
    bus.p1_btn = 4'b1101;
    for (int k = 1; k <= 5; k++) begin
      frame();
      e_x1 = 100 + 2 * k;
    end
    chk_pos("opposite");

    // p2 right clamps at 620
    do_reset();
    bus.p2_btn = 4'b0001;
    for (int k = 1; k <= 70; k++) begin
      frame();
      e_x2 = (500 + 2 * k > 620) ? 620 : 500 + 2 * k;
      if (k == 10 || k == 59 || k == 60 || k == 70) chk_pos("clamp_x2");
    end

    // p1 up clamps at 0
    do_reset();
    bus.p1_btn = 4'b1000;
    for (int k = 1; k <= 60; k++) begin
      frame();
      e_y1 = (100 - 2 * k < 0) ? 0 : 100 - 2 * k;
      if (k == 49 || k == 50 || k == 60) chk_pos("clamp_y1");
    end

    // p2 diagonal up+left
    do_reset();
    bus.p2_btn = 4'b1010;
    for (int k = 1; k <= 5; k++) begin
      frame();
      e_x2 = 500 - 2 * k;
      e_y2 = 100 - 2 * k;
    end
    chk_pos("diagonal");

    // p1 walks into p2: touching allowed, overlap blocked
    do_reset();
    bus.p1_btn = 4'b0001;
    for (int k = 1; k <= 189; k++) begin
      frame();
      e_x1 = 100 + 2 * k;
    end
    chk_pos("approach");
    frame();
    e_x1 = 480;
    chk_pos("touch");
    frame();
    chk_pos("blocked");
    frame();
    chk_pos("still_blocked");

    // Acceleration
    do_reset();
    bus.p1_btn = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      frame();
`ifdef PLAYER_MOTION_ACCEL_EN
      e_x1 = e_x1 + ((k <= 16) ? 2 : 4);
`else
      e_x1 = e_x1 + 2;
`endif
    end
    chk_pos("accel_hold");
    bus.p1_btn = 4'b0000;
    frame();
    chk_pos("accel_release");
    bus.p1_btn = 4'b0001;
    frame();
    e_x1 = e_x1 + 2;
    chk_pos("accel_repress");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
